// File: rtl/mem_write_sched_pkg.sv
// Shared constants and types for the memory-write scheduler.
// Entry layout in the write FIFO is {addr[11:0], data[7:0]}.
package mem_write_sched_pkg;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int EW = AW + DW;

  localparam int ADDR_HI = 19;
  localparam int ADDR_LO = 8;
  localparam int DATA_HI = 7;

  localparam int REQ_CPU  = 0;
  localparam int REQ_FONT = 1;
  localparam int REQ_CLR  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2
  } drain_state_t;

endpackage

// File: rtl/mem_write_sched_rr_arbiter.sv
// Round-robin grant over NREQ requesters.
// The pointer only advances when a grant is actually issued.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid,
  output logic [IW-1:0]   gnt_idx
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;

  // Search from the pointer, wrapping; first set request wins.
  always_comb begin
    int idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    gnt       = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    ptr_d     = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
    if (en && found) begin
      gnt[gnt_idx] = 1'b1;
      gnt_valid    = 1'b1;
      if (gnt_idx == IW'(NREQ - 1))
        ptr_d = '0;
      else
        ptr_d = gnt_idx + IW'(1);
    end
  end

  // Pointer register; requester 0 has priority out of reset.
  always_ff @(posedge clk) begin
    if (rst)
      ptr_q <= '0;
    else
      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_write_sched.sv
// Arbitrates requesters into the write FIFO and drains the FIFO
// into the RAM write port with a we/ack handshake.
module mem_write_sched
  import mem_write_sched_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic             fifo_write,
  output logic [EW-1:0]    fifo_in,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic             fifo_read,
  input  logic [EW-1:0]    fifo_out,
  input  logic             fifo_err,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic             mem_ack,
  output logic             busy,
  output logic             err
);

  logic          arb_en;
  logic [IW-1:0] gnt_idx;

  drain_state_t  state_q, state_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          err_q, err_d;

  // Full is registered in the FIFO, so one write per cycle never overflows.
  assign arb_en = !fifo_full && !rst;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .en        (arb_en),
    .req       (req_valid),
    .gnt       (req_ready),
    .gnt_valid (fifo_write),
    .gnt_idx   (gnt_idx)
  );

  // Route the granted requester's operands to the FIFO input.
  always_comb begin
    fifo_in = {req_addr[gnt_idx*AW +: AW],
               req_data[gnt_idx*DW +: DW]};
  end

  // Drain FSM next-state: read, latch, then hold we until ack.
  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    fifo_read   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_read = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        mem_addr_d  = fifo_out[ADDR_HI:ADDR_LO];
        mem_wdata_d = fifo_out[DATA_HI:0];
        mem_we_d    = 1'b1;
        state_d     = WRITE;
      end
      WRITE: begin
        if (mem_ack) begin
          mem_we_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        mem_we_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
    if (rst)
      fifo_read = 1'b0;
  end

  // Sticky mirror of the FIFO error flag.
  always_comb begin
    err_d = err_q | fifo_err;
  end

  // State and registered outputs; reset abandons any in-flight write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mem_write_sched.sv
// Directed bench for mem_write_sched with a 16-deep FIFO model
// and a log of every write the RAM accepts.
module tb_mem_write_sched;
  import mem_write_sched_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [2:0]    req_valid;
  logic [11:0]   a [3];
  logic [7:0]    d [3];
  logic [35:0]   req_addr;
  logic [23:0]   req_data;
  logic [2:0]    req_ready;
  logic          fifo_write;
  logic [19:0]   fifo_in;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_read;
  logic [19:0]   fifo_out;
  logic          fifo_err;
  logic          mem_we;
  logic [11:0]   mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_ack;
  logic          busy;
  logic          err;
  logic          err_force;

  assign req_addr = {a[2], a[1], a[0]};
  assign req_data = {d[2], d[1], d[0]};

  mem_write_sched #(.NREQ(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_write (fifo_write),
    .fifo_in    (fifo_in),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_read  (fifo_read),
    .fifo_out   (fifo_out),
    .fifo_err   (fifo_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .busy       (busy),
    .err        (err)
  );

  // FIFO model: registered flags and output, no reset.
  logic [19:0] fm_mem [16];
  logic [3:0]  fm_wp  = 4'd0;
  logic [3:0]  fm_rp  = 4'd0;
  logic [4:0]  fm_cnt = 5'd0;
  logic [19:0] fm_out = 20'd0;
  logic        fm_err = 1'b0;
  logic        rd_ok, wr_ok;

  assign rd_ok      = fifo_read && (fm_cnt != 5'd0);
  assign wr_ok      = fifo_write && (fm_cnt != 5'd16);
  assign fifo_full  = (fm_cnt == 5'd16);
  assign fifo_empty = (fm_cnt == 5'd0);
  assign fifo_out   = fm_out;
  assign fifo_err   = fm_err | err_force;

  always @(posedge clk) begin
    if (rd_ok) begin
      fm_out <= fm_mem[fm_rp];
      fm_rp  <= fm_rp + 4'd1;
    end
    if (wr_ok) begin
      fm_mem[fm_wp] <= fifo_in;
      fm_wp         <= fm_wp + 4'd1;
    end
    fm_cnt <= fm_cnt + {4'd0, wr_ok} - {4'd0, rd_ok};
    if ((fifo_read && fm_cnt == 5'd0) ||
        (fifo_write && fm_cnt == 5'd16))
      fm_err <= 1'b1;
  end

  logic [19:0] log_q [$];
  logic [19:0] exp_q [$];

  always @(posedge clk) begin
    if (!rst && mem_we && mem_ack)
      log_q.push_back({mem_addr, mem_wdata});
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag);
    logic [31:0] v;
    chk({tag, "_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      v = 'x;
      if (i < log_q.size())
        v = {12'd0, log_q[i]};
      chk(tag, v, {12'd0, exp_q[i]});
    end
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < maxc) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, {31'd0, busy}, 0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 3'b000;
    mem_ack   = 1'b1;
    err_force = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a[i] = '0;
      d[i] = '0;
    end

    // Reset: strobes gated even with requests pending.
    repeat (2) @(negedge clk);
    req_valid = 3'b111;
    #1;
    chk("rst_ready", {29'd0, req_ready}, 0);
    chk("rst_fwrite", {31'd0, fifo_write}, 0);
    chk("rst_we", {31'd0, mem_we}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_busy", {31'd0, busy}, 0);

    // Single request: we rises three samples after accept.
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 3'b001;
    a[0]      = 12'h200;
    d[0]      = 8'hA5;
    #1;
    chk("single_ready", {29'd0, req_ready}, 32'h1);
    chk("single_fin", {12'd0, fifo_in}, 32'h200A5);
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    chk("single_read", {31'd0, fifo_read}, 1);
    @(negedge clk);
    #1;
    chk("single_we_early", {31'd0, mem_we}, 0);
    @(negedge clk);
    #1;
    chk("single_we", {31'd0, mem_we}, 1);
    chk("single_addr", {20'd0, mem_addr}, 32'h200);
    chk("single_data", {24'd0, mem_wdata}, 32'hA5);
    @(negedge clk);
    #1;
    chk("single_we_done", {31'd0, mem_we}, 0);
    chk("single_busy", {31'd0, busy}, 0);

    // Fairness: pointer reset, then 0,1,2,0,1,2.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    log_q.delete();
    exp_q.delete();
    a[0] = 12'h010; d[0] = 8'h10;
    a[1] = 12'h021; d[1] = 8'h21;
    a[2] = 12'h032; d[2] = 8'h32;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req_valid = 3'b111;
      #1;
      chk("rr_ready", {29'd0, req_ready},
          32'(1 << (k % 3)));
      chk("rr_fin", {12'd0, fifo_in},
          {12'd0, a[k % 3], d[k % 3]});
      exp_q.push_back({a[k % 3], d[k % 3]});
    end
    @(negedge clk);
    req_valid = 3'b000;
    wait_idle(100, "rr_idle");
    chk_log("rr_order");

    // Stalled ack: operands stable, no extra read.
    log_q.delete();
    exp_q.delete();
    mem_ack = 1'b0;
    @(negedge clk);
    req_valid = 3'b001;
    a[0] = 12'h0AB;
    d[0] = 8'h5C;
    #1;
    chk("stall_ready", {29'd0, req_ready}, 32'h1);
    exp_q.push_back(20'h0AB5C);
    @(negedge clk);
    req_valid = 3'b000;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("stall_we", {31'd0, mem_we}, 1);
      chk("stall_addr", {20'd0, mem_addr}, 32'h0AB);
      chk("stall_data", {24'd0, mem_wdata}, 32'h5C);
      chk("stall_read", {31'd0, fifo_read}, 0);
    end

    // Full backpressure: 16 fill the FIFO, 17th refused.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      req_valid = 3'b001;
      a[0] = 12'(i);
      d[0] = 8'(8'h40 + i);
      #1;
      chk("fill_ready", {29'd0, req_ready}, 32'h1);
      exp_q.push_back({12'(i), 8'(8'h40 + i)});
    end
    @(negedge clk);
    a[0] = 12'h010;
    d[0] = 8'h50;
    #1;
    chk("full_ready", {29'd0, req_ready}, 0);
    chk("full_fwrite", {31'd0, fifo_write}, 0);
    @(negedge clk);
    #1;
    chk("full_ready2", {29'd0, req_ready}, 0);
    req_valid = 3'b000;
    mem_ack   = 1'b1;
    wait_idle(200, "full_idle");
    chk_log("full_order");
    chk("full_err", {31'd0, err}, 0);

    // Reset during WRITE: entry lost, remainder drained.
    log_q.delete();
    exp_q.delete();
    mem_ack = 1'b0;
    @(negedge clk);
    req_valid = 3'b001;
    a[0] = 12'h123;
    d[0] = 8'h77;
    #1;
    chk("mid_ready_a", {29'd0, req_ready}, 32'h1);
    @(negedge clk);
    a[0] = 12'h456;
    d[0] = 8'h88;
    #1;
    chk("mid_ready_b", {29'd0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid = 3'b000;
    @(negedge clk);
    #1;
    chk("mid_we", {31'd0, mem_we}, 1);
    chk("mid_addr", {20'd0, mem_addr}, 32'h123);
    rst       = 1'b1;
    req_valid = 3'b111;
    a[0] = 12'h300; d[0] = 8'h33;
    a[1] = 12'h311; d[1] = 8'h44;
    a[2] = 12'h322; d[2] = 8'h55;
    #1;
    chk("mid_rst_ready", {29'd0, req_ready}, 0);
    chk("mid_rst_fwrite", {31'd0, fifo_write}, 0);
    @(negedge clk);
    #1;
    chk("mid_we_drop", {31'd0, mem_we}, 0);
    chk("mid_err", {31'd0, err}, 0);
    chk("mid_busy", {31'd0, busy}, 1);
    chk("mid_rst_read", {31'd0, fifo_read}, 0);
    rst     = 1'b0;
    mem_ack = 1'b1;
    #1;
    chk("mid_ptr0", {29'd0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid = 3'b000;
    exp_q.push_back(20'h45688);
    exp_q.push_back(20'h30033);
    wait_idle(100, "mid_idle");
    chk_log("mid_order");

    // Error mirror: one-cycle pulse, sticky until reset.
    @(negedge clk);
    err_force = 1'b1;
    #1;
    chk("err_pre", {31'd0, err}, 0);
    @(negedge clk);
    err_force = 1'b0;
    #1;
    chk("err_set", {31'd0, err}, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("err_hold", {31'd0, err}, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("err_clr", {31'd0, err}, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_write_sched.md
Name: mem_write_sched

Overview:
- Controller for the 20-bit memory-write request FIFO (entry = {addr[11:0], data[7:0]}).
- Round-robin arbitrates up to NREQ write requesters (CPU store, font loader, screen clear) into the FIFO write port.
- Independently drains the FIFO into the single RAM write port using a we/ack handshake.
- Sits between the requester blocks and the FIFO/RAM; owns every FIFO read/write strobe, so the FIFO never sees a read on empty or a write on full.

Parameters:
- NREQ, 3, number of requesters; index 0 is reset priority.
- AW, 12, address width.
- DW, 8, data width; FIFO entry width = AW+DW = 20.

Ports:
- clk  in  1  system clock; all logic on posedge clk.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  requester i holds a write request.
- req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW].
- req_data  in  NREQ*DW  packed data; requester i at [i*DW +: DW].
- req_ready  out  NREQ  one-hot accept strobe (combinational).
- fifo_write  out  1  FIFO write strobe.
- fifo_in  out  AW+DW  {addr, data} of the granted requester.
- fifo_full  in  1  FIFO full flag.
- fifo_empty  in  1  FIFO empty flag.
- fifo_read  out  1  FIFO read strobe.
- fifo_out  in  AW+DW  FIFO registered output; valid the cycle after fifo_read.
- fifo_err  in  1  FIFO sticky error.
- mem_we  out  1  RAM write request; held until ack.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM data.
- mem_ack  in  1  RAM accepted the write this cycle.
- busy  out  1  drain FSM not IDLE, or FIFO not empty.
- err  out  1  sticky; registered copy of fifo_err.

Behaviour:
- Reset (rst=1 at posedge):
  - FSM→IDLE, rr_ptr←0, err←0, mem_we/mem_addr/mem_wdata←0.
  - While rst=1, req_ready=0, fifo_write=0, fifo_read=0.
  - FIFO contents are not cleared (FIFO has no reset); entries still in the FIFO are drained after rst drops.
- Arbiter (combinational grant, registered pointer):
  - Search req_valid starting at rr_ptr, wrapping modulo NREQ; first set bit wins.
  - If a winner exists and fifo_full=0: req_ready[g]=1, fifo_write=1, fifo_in={req_addr[g], req_data[g]}, rr_ptr←(g+1) mod NREQ.
  - If fifo_full=1: no grant, rr_ptr holds.
  - Requester holds valid/addr/data stable until it sees ready; at most one accept per cycle.
- Drain FSM:
  - IDLE: if fifo_empty=0, assert fifo_read for one cycle → WAIT. Never asserts read when empty.
  - WAIT: fifo_out now valid; latch mem_addr=fifo_out[19:8], mem_wdata=fifo_out[7:0], mem_we←1 → WRITE.
  - WRITE: hold mem_we and operands until mem_ack=1; on ack mem_we←0 → IDLE.
  - Back-to-back entry cost: 3 cycles minimum (read, latch, ack) when ack is immediate.
- Simultaneous FIFO read and write are allowed only when the FIFO is non-empty. A FIFO write while it is empty makes it non-empty next cycle; IDLE reads at the earliest one cycle later, so the FIFO pass-through path is never used.
- Full boundary: the full flag is registered in the FIFO, and the scheduler issues at most one write per cycle. A write that fills the FIFO therefore raises full before the next grant decision.
- err←err | fifo_err every cycle; cleared only by rst.
- Reset mid-WRITE: mem_we drops next cycle and the in-flight entry is lost. The RAM must treat a dropped we as abort.

Decomposition:
- Shared package: AW, DW, entry-field slice constants (ADDR_HI=19, ADDR_LO=8, DATA_HI=7), drain FSM state encoding (IDLE, WAIT, WRITE), requester index constants (REQ_CPU=0, REQ_FONT=1, REQ_CLR=2).
- One natural sub-module: rr_arbiter (NREQ-wide round-robin grant with registered pointer), instantiated once.
- Drain FSM stays inline.

Test Plan:
- Reset then single request: req_valid=3'b001, addr=0x200, data=0xA5, mem_ack tied 1 → req_ready[0] same cycle; mem_we=1 with mem_addr=0x200, mem_wdata=0xA5 exactly 3 cycles later; busy=0 afterwards.
- Round-robin fairness: all three valid continuously for 6 cycles, FIFO not full → grants 0,1,2,0,1,2; each requester accepted twice.
- Full backpressure: hold mem_ack=0, issue 16 writes (addr 0x000..0x00F) → 16th raises fifo_full; 17th request gets no req_ready; fifo_err stays 0. Then release ack → entries reach RAM in order 0x000..0x00F.
- Stalled ack: mem_ack=0 for 5 cycles in WRITE → mem_we, mem_addr, mem_wdata stable all 5 cycles; no extra fifo_read issued.
- Mid-operation reset: rst=1 during WRITE of addr 0x123 → next cycle mem_we=0, req_ready=0, err=0, rr_ptr=0; the remaining FIFO entry is drained after rst drops.
- Error mirror: force fifo_err=1 for one cycle → err=1 next cycle and stays set until rst.
